// File: rtl/ex_pkg.sv
// ---------------------------------------------------------------------------
// ex_pkg -- shared widths, ALU selector/opcode encodings, multiplier FSM
// states and helpers for the MIPS execute stage.
//
// Contents:
//   * bus widths        : REG_DATA_W, REG_ADDR_W, ALU_OP_W, ALU_SEL_W, DOUBLE_REG_W
//   * alusel codes      : EXE_RES_*
//   * aluop codes       : EXE_OP_*
//   * mul_state_e       : iterative multiplier FSM states
//   * abs32()           : two's-complement magnitude (0x80000000 maps to itself)
// ---------------------------------------------------------------------------
package ex_pkg;

   localparam int REG_DATA_W   = 32;
   localparam int REG_ADDR_W   = 5;
   localparam int ALU_OP_W     = 8;
   localparam int ALU_SEL_W    = 3;
   localparam int DOUBLE_REG_W = 64;

   // Result class selectors
   localparam logic [ALU_SEL_W-1:0] EXE_RES_NOP   = 3'b000;
   localparam logic [ALU_SEL_W-1:0] EXE_RES_LOGIC = 3'b001;
   localparam logic [ALU_SEL_W-1:0] EXE_RES_SHIFT = 3'b010;
   localparam logic [ALU_SEL_W-1:0] EXE_RES_MOVE  = 3'b011;

   // Operation subtypes
   localparam logic [ALU_OP_W-1:0] EXE_OP_NOP   = 8'b0000_0000;
   localparam logic [ALU_OP_W-1:0] EXE_OP_AND   = 8'b0010_0100;
   localparam logic [ALU_OP_W-1:0] EXE_OP_OR    = 8'b0010_0101;
   localparam logic [ALU_OP_W-1:0] EXE_OP_XOR   = 8'b0010_0110;
   localparam logic [ALU_OP_W-1:0] EXE_OP_NOR   = 8'b0010_0111;
   localparam logic [ALU_OP_W-1:0] EXE_OP_SLL   = 8'b0111_1100;
   localparam logic [ALU_OP_W-1:0] EXE_OP_SRL   = 8'b0000_0010;
   localparam logic [ALU_OP_W-1:0] EXE_OP_SRA   = 8'b0000_0011;
   localparam logic [ALU_OP_W-1:0] EXE_OP_MOVZ  = 8'b0000_1010;
   localparam logic [ALU_OP_W-1:0] EXE_OP_MOVN  = 8'b0000_1011;
   localparam logic [ALU_OP_W-1:0] EXE_OP_MFHI  = 8'b0001_0000;
   localparam logic [ALU_OP_W-1:0] EXE_OP_MTHI  = 8'b0001_0001;
   localparam logic [ALU_OP_W-1:0] EXE_OP_MFLO  = 8'b0001_0010;
   localparam logic [ALU_OP_W-1:0] EXE_OP_MTLO  = 8'b0001_0011;
   localparam logic [ALU_OP_W-1:0] EXE_OP_MULT  = 8'b0001_1000;
   localparam logic [ALU_OP_W-1:0] EXE_OP_MULTU = 8'b0001_1001;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_BUSY = 2'd1,
      MUL_DONE = 2'd2
   } mul_state_e;

   // Magnitude of a signed 32-bit value, read back as unsigned; the most
   // negative value has no positive counterpart and stays 0x80000000.
   function automatic logic [REG_DATA_W-1:0] abs32(input logic [REG_DATA_W-1:0] v);
      return v[REG_DATA_W-1] ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/mul_iter.sv
// ---------------------------------------------------------------------------
// mul_iter -- iterative 32x32 shift-add multiplier, one partial product per
// cycle. Signed operation works on magnitudes and negates the product at the
// end when the operand signs differ.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start_i        begin an operation (sampled only in IDLE)
//   signed_op_i    1 = MULT (signed), 0 = MULTU
//   opa_i, opb_i   32-bit operands
//   busy_o         high during the 32 accumulate cycles
//   done_o         one-cycle pulse when result_o is valid
//   result_o       64-bit product, valid while done_o is high
// ---------------------------------------------------------------------------
module mul_iter
   import ex_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start_i,
   input  logic                    signed_op_i,
   input  logic [REG_DATA_W-1:0]   opa_i,
   input  logic [REG_DATA_W-1:0]   opb_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic [DOUBLE_REG_W-1:0] result_o
);

   mul_state_e                state_q, state_d;
   logic [REG_DATA_W-1:0]     mcand_q, mcand_d;
   logic [REG_DATA_W-1:0]     mplier_q, mplier_d;
   logic [DOUBLE_REG_W-1:0]   prod_q, prod_d;
   logic [4:0]                count_q, count_d;
   logic                      neg_q, neg_d;
   logic [REG_DATA_W:0]       partial;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= MUL_IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         count_q  <= '0;
         neg_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
         count_q  <= count_d;
         neg_q    <= neg_d;
      end
   end

   // NOTE: every signal written here gets a default first, so no path
   // through the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      prod_d   = prod_q;
      count_d  = count_q;
      neg_d    = neg_q;
      busy_o   = 1'b0;
      done_o   = 1'b0;
      result_o = '0;

      // 33-bit add into the upper half keeps the carry; the following right
      // shift drops it back into bit 63, so no product bit is ever lost.
      partial = {1'b0, prod_q[DOUBLE_REG_W-1:REG_DATA_W]}
              + (mplier_q[0] ? {1'b0, mcand_q} : 33'd0);

      case (state_q)
         MUL_IDLE: begin
            if (start_i) begin
               mcand_d  = signed_op_i ? abs32(opa_i) : opa_i;
               mplier_d = signed_op_i ? abs32(opb_i) : opb_i;
               neg_d    = signed_op_i & (opa_i[REG_DATA_W-1] ^ opb_i[REG_DATA_W-1]);
               prod_d   = '0;
               count_d  = '0;
               state_d  = MUL_BUSY;
            end
         end
         MUL_BUSY: begin
            busy_o   = 1'b1;
            prod_d   = {partial, prod_q[REG_DATA_W-1:1]};
            mplier_d = mplier_q >> 1;
            count_d  = count_q + 5'd1;
            if (count_q == 5'd31) begin
               state_d = MUL_DONE;
            end
         end
         MUL_DONE: begin
            done_o   = 1'b1;
            result_o = neg_q ? (~prod_q + 64'd1) : prod_q;
            state_d  = MUL_IDLE;
         end
         default: begin
            state_d = MUL_IDLE;
         end
      endcase
   end

endmodule

// File: rtl/ex.sv
// ---------------------------------------------------------------------------
// ex -- execute stage of the five-stage MIPS pipeline.
// Computes the GPR result (logic / shift / move), HI/LO write requests
// (MTHI, MTLO, MULT, MULTU) and the stall request for the iterative
// multiplier. Everything except the multiplier is combinational.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   alusel_i, aluop_i                decoded result class / operation
//   reg1_i, reg2_i                   operands
//   waddr_i, wreg_i                  GPR destination / write enable
//   hi_i, lo_i                       architectural HI/LO
//   mem_whilo_i, mem_hi_i, mem_lo_i  HI/LO write in flight in MEM
//   wb_whilo_i, wb_hi_i, wb_lo_i     HI/LO write in flight in WB
//   wdata_o, waddr_o, wreg_o         GPR write for EX/MEM and ID forwarding
//   whilo_o, hi_o, lo_o              HI/LO write request
//   stallreq_o                       hold PC, IF/ID and ID/EX
// ---------------------------------------------------------------------------
module ex
   import ex_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ALU_SEL_W-1:0]  alusel_i,
   input  logic [ALU_OP_W-1:0]   aluop_i,
   input  logic [REG_DATA_W-1:0] reg1_i,
   input  logic [REG_DATA_W-1:0] reg2_i,
   input  logic [REG_ADDR_W-1:0] waddr_i,
   input  logic                  wreg_i,
   input  logic [REG_DATA_W-1:0] hi_i,
   input  logic [REG_DATA_W-1:0] lo_i,
   input  logic                  mem_whilo_i,
   input  logic [REG_DATA_W-1:0] mem_hi_i,
   input  logic [REG_DATA_W-1:0] mem_lo_i,
   input  logic                  wb_whilo_i,
   input  logic [REG_DATA_W-1:0] wb_hi_i,
   input  logic [REG_DATA_W-1:0] wb_lo_i,
   output logic [REG_DATA_W-1:0] wdata_o,
   output logic [REG_ADDR_W-1:0] waddr_o,
   output logic                  wreg_o,
   output logic                  whilo_o,
   output logic [REG_DATA_W-1:0] hi_o,
   output logic [REG_DATA_W-1:0] lo_o,
   output logic                  stallreq_o
);

   logic [REG_DATA_W-1:0]   cur_hi, cur_lo;
   logic [REG_DATA_W-1:0]   logic_res, shift_res, move_res;
   logic                    is_mul, mul_start, mul_busy, mul_done;
   logic [DOUBLE_REG_W-1:0] mul_result;

   // Youngest in-flight HI/LO write wins: MEM, then WB, then the register file.
   always_comb begin
      if (mem_whilo_i) begin
         cur_hi = mem_hi_i;
         cur_lo = mem_lo_i;
      end else if (wb_whilo_i) begin
         cur_hi = wb_hi_i;
         cur_lo = wb_lo_i;
      end else begin
         cur_hi = hi_i;
         cur_lo = lo_i;
      end
   end

   always_comb begin
      case (aluop_i)
         EXE_OP_AND: logic_res = reg1_i & reg2_i;
         EXE_OP_OR:  logic_res = reg1_i | reg2_i;
         EXE_OP_XOR: logic_res = reg1_i ^ reg2_i;
         EXE_OP_NOR: logic_res = ~(reg1_i | reg2_i);
         default:    logic_res = '0;
      endcase
   end

   always_comb begin
      case (aluop_i)
         EXE_OP_SLL: shift_res = reg2_i << reg1_i[4:0];
         EXE_OP_SRL: shift_res = reg2_i >> reg1_i[4:0];
         EXE_OP_SRA: shift_res = $signed(reg2_i) >>> reg1_i[4:0];
         default:    shift_res = '0;
      endcase
   end

   // MOVZ/MOVN condition was already folded into wreg_i by decode.
   always_comb begin
      case (aluop_i)
         EXE_OP_MOVZ, EXE_OP_MOVN: move_res = reg1_i;
         EXE_OP_MFHI:              move_res = cur_hi;
         EXE_OP_MFLO:              move_res = cur_lo;
         default:                  move_res = '0;
      endcase
   end

   assign is_mul = (aluop_i == EXE_OP_MULT) || (aluop_i == EXE_OP_MULTU);

   // ID/EX keeps presenting the multiply through BUSY and DONE, so a start is
   // only a start while the multiplier is idle.
   assign mul_start = ~rst & is_mul & ~mul_busy & ~mul_done;

   mul_iter u_mul_iter (
      .clk         (clk),
      .rst         (rst),
      .start_i     (mul_start),
      .signed_op_i (aluop_i == EXE_OP_MULT),
      .opa_i       (reg1_i),
      .opb_i       (reg2_i),
      .busy_o      (mul_busy),
      .done_o      (mul_done),
      .result_o    (mul_result)
   );

   always_comb begin
      wdata_o    = '0;
      waddr_o    = '0;
      wreg_o     = 1'b0;
      whilo_o    = 1'b0;
      hi_o       = '0;
      lo_o       = '0;
      stallreq_o = 1'b0;
      if (!rst) begin
         waddr_o    = waddr_i;
         wreg_o     = wreg_i;
         stallreq_o = mul_start | mul_busy;
         case (alusel_i)
            EXE_RES_LOGIC: wdata_o = logic_res;
            EXE_RES_SHIFT: wdata_o = shift_res;
            EXE_RES_MOVE:  wdata_o = move_res;
            default:       wdata_o = '0;
         endcase
         if (mul_done) begin
            whilo_o      = 1'b1;
            {hi_o, lo_o} = mul_result;
         end else if (aluop_i == EXE_OP_MTHI) begin
            whilo_o = 1'b1;
            hi_o    = reg1_i;
            lo_o    = cur_lo;
         end else if (aluop_i == EXE_OP_MTLO) begin
            whilo_o = 1'b1;
            hi_o    = cur_hi;
            lo_o    = reg1_i;
         end
      end
   end

endmodule

// File: tb/tb_ex.sv
// ---------------------------------------------------------------------------
// tb_ex -- self-checking bench for the MIPS execute stage.
// A behavioural model predicts every output each cycle from the instruction
// semantics (plain arithmetic plus an elapsed-cycle count for multiplies);
// directed tests add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_ex;
   import ex_pkg::*;

   logic        clk;
   logic        rst;
   logic [2:0]  alusel_i;
   logic [7:0]  aluop_i;
   logic [31:0] reg1_i, reg2_i;
   logic [4:0]  waddr_i;
   logic        wreg_i;
   logic [31:0] hi_i, lo_i;
   logic        mem_whilo_i, wb_whilo_i;
   logic [31:0] mem_hi_i, mem_lo_i, wb_hi_i, wb_lo_i;
   logic [31:0] wdata_o;
   logic [4:0]  waddr_o;
   logic        wreg_o, whilo_o, stallreq_o;
   logic [31:0] hi_o, lo_o;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 0;

   // Model state: a multiply in flight and the cycles since its detect cycle.
   bit          m_active  = 0;
   int          m_elapsed = 0;
   logic [63:0] m_prod    = '0;

   ex dut (
      .clk         (clk),
      .rst         (rst),
      .alusel_i    (alusel_i),
      .aluop_i     (aluop_i),
      .reg1_i      (reg1_i),
      .reg2_i      (reg2_i),
      .waddr_i     (waddr_i),
      .wreg_i      (wreg_i),
      .hi_i        (hi_i),
      .lo_i        (lo_i),
      .mem_whilo_i (mem_whilo_i),
      .mem_hi_i    (mem_hi_i),
      .mem_lo_i    (mem_lo_i),
      .wb_whilo_i  (wb_whilo_i),
      .wb_hi_i     (wb_hi_i),
      .wb_lo_i     (wb_lo_i),
      .wdata_o     (wdata_o),
      .waddr_o     (waddr_o),
      .wreg_o      (wreg_o),
      .whilo_o     (whilo_o),
      .hi_o        (hi_o),
      .lo_o        (lo_o),
      .stallreq_o  (stallreq_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic bit is_mul(input logic [7:0] op);
      return (op == EXE_OP_MULT) || (op == EXE_OP_MULTU);
   endfunction

   function automatic logic [63:0] ref_mul(input logic [7:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      int     ia, ib;
      longint sa, sb;
      if (op == EXE_OP_MULTU) return {32'd0, a} * {32'd0, b};
      ia = a;
      ib = b;
      sa = ia;
      sb = ib;
      return sa * sb;
   endfunction

   function automatic logic [31:0] m_cur_hi();
      return mem_whilo_i ? mem_hi_i : (wb_whilo_i ? wb_hi_i : hi_i);
   endfunction

   function automatic logic [31:0] m_cur_lo();
      return mem_whilo_i ? mem_lo_i : (wb_whilo_i ? wb_lo_i : lo_i);
   endfunction

   function automatic logic [31:0] m_wdata();
      int sv;
      int amt;
      amt = int'(reg1_i[4:0]);
      sv  = reg2_i;
      if (alusel_i == EXE_RES_LOGIC) begin
         if (aluop_i == EXE_OP_AND) return reg1_i & reg2_i;
         if (aluop_i == EXE_OP_OR)  return reg1_i | reg2_i;
         if (aluop_i == EXE_OP_XOR) return reg1_i ^ reg2_i;
         if (aluop_i == EXE_OP_NOR) return ~(reg1_i | reg2_i);
      end else if (alusel_i == EXE_RES_SHIFT) begin
         if (aluop_i == EXE_OP_SLL) return reg2_i << amt;
         if (aluop_i == EXE_OP_SRL) return reg2_i >> amt;
         if (aluop_i == EXE_OP_SRA) return sv >>> amt;
      end else if (alusel_i == EXE_RES_MOVE) begin
         if (aluop_i == EXE_OP_MOVZ || aluop_i == EXE_OP_MOVN) return reg1_i;
         if (aluop_i == EXE_OP_MFHI) return m_cur_hi();
         if (aluop_i == EXE_OP_MFLO) return m_cur_lo();
      end
      return 32'd0;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_active = 0;
      end else if (m_active) begin
         if (m_elapsed == 33) m_active = 0;
         else m_elapsed++;
      end else if (is_mul(aluop_i)) begin
         m_active  = 1;
         m_elapsed = 1;
         m_prod    = ref_mul(aluop_i, reg1_i, reg2_i);
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         logic [31:0] e_wdata, e_hi, e_lo;
         logic [4:0]  e_waddr;
         logic        e_wreg, e_whilo, e_stall;
         e_wdata = 0; e_waddr = 0; e_wreg = 0; e_whilo = 0; e_hi = 0; e_lo = 0; e_stall = 0;
         if (!rst) begin
            e_wdata = m_wdata();
            e_waddr = waddr_i;
            e_wreg  = wreg_i;
            e_stall = (!m_active && is_mul(aluop_i)) || (m_active && m_elapsed <= 32);
            if (m_active && m_elapsed == 33) begin
               e_whilo = 1;
               {e_hi, e_lo} = m_prod;
            end else if (aluop_i == EXE_OP_MTHI) begin
               e_whilo = 1; e_hi = reg1_i; e_lo = m_cur_lo();
            end else if (aluop_i == EXE_OP_MTLO) begin
               e_whilo = 1; e_hi = m_cur_hi(); e_lo = reg1_i;
            end
         end
         check("mdl_wdata", 64'(wdata_o), 64'(e_wdata));
         check("mdl_waddr", 64'(waddr_o), 64'(e_waddr));
         check("mdl_wreg", 64'(wreg_o), 64'(e_wreg));
         check("mdl_whilo", 64'(whilo_o), 64'(e_whilo));
         check("mdl_hi", 64'(hi_o), 64'(e_hi));
         check("mdl_lo", 64'(lo_o), 64'(e_lo));
         check("mdl_stall", 64'(stallreq_o), 64'(e_stall));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic apply(input logic [2:0] sel, input logic [7:0] op,
                        input logic [31:0] a, input logic [31:0] b);
      step();
      alusel_i = sel;
      aluop_i  = op;
      reg1_i   = a;
      reg2_i   = b;
   endtask

   // Issues a multiply, counts stall cycles up to DONE and checks the result.
   task automatic do_mul(input string name, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo);
      int stall_cnt;
      bit seen;
      stall_cnt = 0;
      seen      = 0;
      apply(EXE_RES_NOP, op, a, b);
      wreg_i = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         settle();
         if (stallreq_o) stall_cnt++;
         if (whilo_o) begin
            seen = 1;
            check({name, "_hi"}, 64'(hi_o), 64'(exp_hi));
            check({name, "_lo"}, 64'(lo_o), 64'(exp_lo));
            check({name, "_stall_in_done"}, 64'(stallreq_o), 64'd0);
         end
      end
      check({name, "_done_seen"}, 64'(seen), 64'd1);
      check({name, "_stall_cycles"}, 64'(stall_cnt), 64'd33);
   endtask

   // ---------------- directed test sequence ----------------
   initial begin
      int whilo_seen;
      rst = 1'b1;
      alusel_i = EXE_RES_LOGIC; aluop_i = EXE_OP_OR;
      reg1_i = 32'h1; reg2_i = 32'h2; waddr_i = 5'd7; wreg_i = 1'b1;
      hi_i = 32'h1; lo_i = 32'h11;
      mem_whilo_i = 0; mem_hi_i = 32'h3; mem_lo_i = 32'h33;
      wb_whilo_i = 0; wb_hi_i = 32'h2; wb_lo_i = 32'h22;
      cmp_en = 1;

      // Reset state: all outputs zero regardless of inputs
      settle();
      check("rst_wdata", 64'(wdata_o), 64'd0);
      check("rst_wreg", 64'(wreg_o), 64'd0);
      check("rst_waddr", 64'(waddr_o), 64'd0);
      repeat (2) step();
      rst = 1'b0;

      // ORI-style logic op
      apply(EXE_RES_LOGIC, EXE_OP_OR, 32'h1234_0000, 32'h0000_FFFF);
      waddr_i = 5'd5; wreg_i = 1'b1;
      settle();
      check("ori_wdata", 64'(wdata_o), 64'h1234_FFFF);
      check("ori_wreg", 64'(wreg_o), 64'd1);
      check("ori_waddr", 64'(waddr_o), 64'd5);

      // SRA fills with the sign bit
      apply(EXE_RES_SHIFT, EXE_OP_SRA, 32'd4, 32'h8000_0000);
      settle();
      check("sra_wdata", 64'(wdata_o), 64'hF800_0000);

      // Remaining ALU ops, checked by the model
      apply(EXE_RES_LOGIC, EXE_OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF);
      apply(EXE_RES_LOGIC, EXE_OP_XOR, 32'hAAAA_5555, 32'hFFFF_0000);
      apply(EXE_RES_LOGIC, EXE_OP_NOR, 32'h0000_00F0, 32'h0F00_0000);
      apply(EXE_RES_SHIFT, EXE_OP_SLL, 32'd31, 32'h0000_0003);
      apply(EXE_RES_SHIFT, EXE_OP_SRL, 32'd36, 32'h8000_0010);
      apply(EXE_RES_SHIFT, EXE_OP_SRA, 32'd0, 32'h8765_4321);
      apply(EXE_RES_MOVE, EXE_OP_MOVZ, 32'hCAFE_F00D, 32'h0);
      apply(EXE_RES_MOVE, EXE_OP_MOVN, 32'h0BAD_BEEF, 32'h1);
      apply(EXE_RES_LOGIC, 8'hFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      settle();
      check("unknown_op_wdata", 64'(wdata_o), 64'd0);

      // MFHI forwarding priority
      apply(EXE_RES_MOVE, EXE_OP_MFHI, 32'h0, 32'h0);
      hi_i = 32'd1; wb_hi_i = 32'd2; wb_whilo_i = 1; mem_hi_i = 32'd3; mem_whilo_i = 1;
      settle();
      check("mfhi_mem", 64'(wdata_o), 64'd3);
      step(); mem_whilo_i = 0;
      settle();
      check("mfhi_wb", 64'(wdata_o), 64'd2);
      step(); wb_whilo_i = 0;
      settle();
      check("mfhi_reg", 64'(wdata_o), 64'd1);
      apply(EXE_RES_MOVE, EXE_OP_MFLO, 32'h0, 32'h0);
      wb_whilo_i = 1;

      // MTLO / MTHI
      apply(EXE_RES_NOP, EXE_OP_MTLO, 32'hDEAD_BEEF, 32'h0);
      wb_whilo_i = 0; hi_i = 32'h5; wreg_i = 1'b0;
      settle();
      check("mtlo_whilo", 64'(whilo_o), 64'd1);
      check("mtlo_hi", 64'(hi_o), 64'h5);
      check("mtlo_lo", 64'(lo_o), 64'hDEAD_BEEF);
      check("mtlo_wdata", 64'(wdata_o), 64'd0);
      apply(EXE_RES_NOP, EXE_OP_MTHI, 32'h1357_9BDF, 32'h0);
      mem_whilo_i = 1;
      apply(EXE_RES_NOP, EXE_OP_NOP, 32'h0, 32'h0);
      mem_whilo_i = 0;

      // Multiplies
      do_mul("mult_m1x2", EXE_OP_MULT, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      apply(EXE_RES_NOP, EXE_OP_NOP, 32'h0, 32'h0);
      settle();
      check("mult_whilo_after", 64'(whilo_o), 64'd0);
      do_mul("multu_m1x2", EXE_OP_MULTU, 32'hFFFF_FFFF, 32'h2, 32'h1, 32'hFFFF_FFFE);
      // Back-to-back: the next multiply arrives the cycle after DONE
      do_mul("mult_min_sq", EXE_OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
      do_mul("mult_zero", EXE_OP_MULT, 32'h0, 32'h8765_4321, 32'h0, 32'h0);
      do_mul("mult_neg_pos", EXE_OP_MULT, 32'h7FFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h8000_0003);

      // Reset in BUSY count 10: the multiply is abandoned
      apply(EXE_RES_NOP, EXE_OP_MULT, 32'd7, 32'd9);
      repeat (11) step();
      rst = 1'b1; aluop_i = EXE_OP_NOP;
      step();
      rst = 1'b0;
      settle();
      check("rst_mid_stall", 64'(stallreq_o), 64'd0);
      whilo_seen = 0;
      for (int c = 0; c < 40; c++) begin
         settle();
         if (whilo_o) whilo_seen++;
      end
      check("rst_mid_no_whilo", 64'(whilo_seen), 64'd0);
      do_mul("mult_3x5", EXE_OP_MULT, 32'd3, 32'd5, 32'd0, 32'd15);
      apply(EXE_RES_NOP, EXE_OP_NOP, 32'h0, 32'h0);
      repeat (2) step();

      cmp_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
